pcie_ingress_decoder: RTL



---
 rtl/pcie_ingress_decoder.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pcie_ingress_decoder.sv
// pcie_ingress_decoder
//   Parses host-issued 32-bit Memory Write TLPs aimed at BAR0. Writes into the
//   register window update latched buffer-address registers. Writes into the
//   command window produce one-cycle command strobes and latched operands.
//   Any other TLP is consumed and dropped, and the drop is counted.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   i_rx_data/valid      receive dword stream and its qualifier
//   i_rx_sof/eof         first/last dword markers (qualified by valid)
//   o_rx_ready           dword accepted this cycle (low only while dispatching)
//   o_*_addr, o_buffer_size, o_ping_value   latched register window contents
//   o_update_buf(_stb)   buffer-ready bits from register 1 and their write pulse
//   o_reg_write_stb      pulse on any register-window write
//   o_device_select, o_cmd_flg_fifo, o_cmd_data_count, o_cmd_data_address
//                        latched command fields
//   o_cmd_*_stb, o_cmd_unknown  one-cycle command pulses
//   o_drop_count         saturating count of dropped TLPs
module pcie_ingress_decoder #(
    parameter int         REG_COUNT     = 8,
    parameter logic [9:0] CMD_INDEX     = 10'h010,
    parameter int         ADDR_LSB_MASK = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_rx_sof,
    input  logic        i_rx_eof,
    output logic        o_rx_ready,
    output logic [31:0] o_status_addr,
    output logic [31:0] o_write_a_addr,
    output logic [31:0] o_write_b_addr,
    output logic [31:0] o_read_a_addr,
    output logic [31:0] o_read_b_addr,
    output logic [31:0] o_buffer_size,
    output logic [31:0] o_ping_value,
    output logic [1:0]  o_update_buf,
    output logic        o_update_buf_stb,
    output logic        o_reg_write_stb,
    output logic [3:0]  o_device_select,
    output logic        o_cmd_rst_stb,
    output logic        o_cmd_wr_stb,
    output logic        o_cmd_rd_stb,
    output logic        o_cmd_ping_stb,
    output logic        o_cmd_rd_cfg_stb,
    output logic        o_cmd_unknown,
    output logic        o_cmd_flg_fifo,
    output logic [31:0] o_cmd_data_count,
    output logic [31:0] o_cmd_data_address,
    output logic [15:0] o_drop_count
);

    typedef enum logic [2:0] {IDLE, HDR1, HDR2, DATA, DISPATCH, DROP} state_t;

    state_t      state_q, state_d;
    logic [9:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        cmd_mode_q, cmd_mode_d;
    logic [2:0]  tgt_q, tgt_d;
    logic [31:0] pay_q [3];
    logic [31:0] pay_d [3];
    logic        rdy_q;
    logic [1:0]  drop_inc;
    logic        restart;
    logic        xfer;
    logic [2:0]  cnt_inc;
    logic [31:0] idx;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign xfer       = i_rx_valid && rdy_q;
    assign o_rx_ready = rdy_q;
    assign idx        = 32'(i_rx_data[ADDR_LSB_MASK-1:2]);
    // Payload counter saturates at 4 so an over-long payload can never alias a legal length.
    assign cnt_inc    = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        cmd_mode_d = cmd_mode_q;
        tgt_d      = tgt_q;
        pay_d      = pay_q;
        drop_inc   = 2'd0;
        restart    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer && i_rx_sof) restart = 1'b1;
            end
            HDR1: begin
                if (xfer) begin
                    if (i_rx_sof) begin
                        drop_inc = 2'd1;
                        restart  = 1'b1;
                    end else if (i_rx_eof) begin
                        drop_inc = 2'd1;
                        state_d  = IDLE;
                    end else begin
                        state_d = HDR2;
                    end
                end
            end
            HDR2: begin
                if (xfer) begin
                    if (i_rx_sof) begin
                        drop_inc = 2'd1;
                        restart  = 1'b1;
                    end else if (i_rx_eof) begin
                        drop_inc = 2'd1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = 3'd0;
                        tgt_d = idx[2:0];
                        if (idx < 32'(REG_COUNT) && len_q == 10'd1) begin
                            cmd_mode_d = 1'b0;
                            state_d    = DATA;
                        end else if (idx == 32'(CMD_INDEX) && len_q == 10'd3) begin
                            cmd_mode_d = 1'b1;
                            state_d    = DATA;
                        end else begin
                            state_d = DROP;
                        end
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    if (i_rx_sof) begin
                        drop_inc = 2'd1;
                        restart  = 1'b1;
                    end else begin
                        if (cnt_q < 3'd3) pay_d[cnt_q[1:0]] = i_rx_data;
                        cnt_d = cnt_inc;
                        if (i_rx_eof) begin
                            if ({7'd0, cnt_inc} == len_q) begin
                                state_d = DISPATCH;
                            end else begin
                                drop_inc = 2'd1;
                                state_d  = IDLE;
                            end
                        end
                    end
                end
            end
            DISPATCH: state_d = IDLE;
            DROP: begin
                if (xfer && i_rx_eof) begin
                    drop_inc = 2'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The current dword starts a new TLP (fresh or after an aborted one): parse it as DW0.
        if (restart) begin
            if (i_rx_eof) begin
                drop_inc = drop_inc + 2'd1;
                state_d  = IDLE;
            end else if (i_rx_data[30:24] == 7'h40) begin
                len_d   = i_rx_data[9:0];
                state_d = HDR1;
            end else begin
                state_d = DROP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            cmd_mode_q <= 1'b0;
            tgt_q      <= '0;
            pay_q      <= '{default: '0};
            rdy_q      <= 1'b0;
            o_drop_count <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            cmd_mode_q <= cmd_mode_d;
            tgt_q      <= tgt_d;
            pay_q      <= pay_d;
            rdy_q      <= (state_d != DISPATCH);
            o_drop_count <= sat_add16(o_drop_count, drop_inc);
        end
    end

    // Outputs change only on the edge that leaves DISPATCH; strobes last one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_status_addr      <= '0;
            o_write_a_addr     <= '0;
            o_write_b_addr     <= '0;
            o_read_a_addr      <= '0;
            o_read_b_addr      <= '0;
            o_buffer_size      <= '0;
            o_ping_value       <= '0;
            o_update_buf       <= '0;
            o_update_buf_stb   <= 1'b0;
            o_reg_write_stb    <= 1'b0;
            o_device_select    <= '0;
            o_cmd_rst_stb      <= 1'b0;
            o_cmd_wr_stb       <= 1'b0;
            o_cmd_rd_stb       <= 1'b0;
            o_cmd_ping_stb     <= 1'b0;
            o_cmd_rd_cfg_stb   <= 1'b0;
            o_cmd_unknown      <= 1'b0;
            o_cmd_flg_fifo     <= 1'b0;
            o_cmd_data_count   <= '0;
            o_cmd_data_address <= '0;
        end else begin
            o_update_buf_stb <= 1'b0;
            o_reg_write_stb  <= 1'b0;
            o_cmd_rst_stb    <= 1'b0;
            o_cmd_wr_stb     <= 1'b0;
            o_cmd_rd_stb     <= 1'b0;
            o_cmd_ping_stb   <= 1'b0;
            o_cmd_rd_cfg_stb <= 1'b0;
            o_cmd_unknown    <= 1'b0;
            if (state_q == DISPATCH) begin
                if (!cmd_mode_q) begin
                    o_reg_write_stb <= 1'b1;
                    case (tgt_q)
                        3'd0: o_status_addr  <= pay_q[0];
                        3'd1: begin
                            o_update_buf     <= pay_q[0][1:0];
                            o_update_buf_stb <= 1'b1;
                        end
                        3'd2: o_write_a_addr <= pay_q[0];
                        3'd3: o_write_b_addr <= pay_q[0];
                        3'd4: o_read_a_addr  <= pay_q[0];
                        3'd5: o_read_b_addr  <= pay_q[0];
                        3'd6: o_buffer_size  <= pay_q[0];
                        default: o_ping_value <= pay_q[0];
                    endcase
                end else begin
                    o_device_select    <= pay_q[0][7:4];
                    o_cmd_flg_fifo     <= pay_q[0][31];
                    o_cmd_data_count   <= pay_q[1];
                    o_cmd_data_address <= pay_q[2];
                    case (pay_q[0][3:0])
                        4'd0:    o_cmd_rst_stb    <= 1'b1;
                        4'd1:    o_cmd_wr_stb     <= 1'b1;
                        4'd2:    o_cmd_rd_stb     <= 1'b1;
                        4'd3:    o_cmd_ping_stb   <= 1'b1;
                        4'd4:    o_cmd_rd_cfg_stb <= 1'b1;
                        default: o_cmd_unknown    <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule
